// File: rtl/ksw_pkg.sv
// ksw_pkg: shared score constants, gap defaults and saturating arithmetic for the Gotoh PE array
package ksw_pkg;

    localparam int SCORE_W   = 16;
    localparam int GAP_Q     = 4;
    localparam int GAP_E     = 2;
    localparam int SCORE_MIN = -(2 ** (SCORE_W - 1));
    localparam int SCORE_MAX = (2 ** (SCORE_W - 1)) - 1;

    typedef logic signed [SCORE_W-1:0] score_t;

    // Clamp a wide intermediate into the signed range of a w-bit score.
    function automatic int sat_clip(input longint v, input int w);
        longint lo;
        longint hi;
        lo = -(longint'(1) << (w - 1));
        hi = (longint'(1) << (w - 1)) - 1;
        return int'((v < lo) ? lo : (v > hi) ? hi : v);
    endfunction

    function automatic int sat_add(input int a, input int b, input int w);
        return sat_clip(longint'(a) + longint'(b), w);
    endfunction

    function automatic int sat_sub(input int a, input int b, input int w);
        return sat_clip(longint'(a) - longint'(b), w);
    endfunction

endpackage

// File: rtl/ksw_sat_max3.sv
// ksw_sat_max3: signed three-way max of already-saturated H candidates (diag, E, F)
module ksw_sat_max3 #(
    parameter int W = 16
) (
    input  logic signed [W-1:0] i_a,
    input  logic signed [W-1:0] i_b,
    input  logic signed [W-1:0] i_c,
    output logic signed [W-1:0] o_y
);

    logic signed [W-1:0] w_ab;

    // Pairwise reduction; inputs are in range so no further saturation is needed.
    always_comb begin
        w_ab = (i_a > i_b) ? i_a : i_b;
        o_y  = (w_ab > i_c) ? w_ab : i_c;
    end

endmodule

// File: rtl/ksw_pe_cell.sv
// ksw_pe_cell: one affine-gap systolic PE owning a query column; optional local floor via KSW_LOCAL_CLAMP_EN
module ksw_pe_cell
    import ksw_pkg::*;
#(
    parameter int SCORE_WIDTH = SCORE_W,
    parameter int POS_WIDTH   = 12,
    parameter int GAP_OPEN    = GAP_Q,
    parameter int GAP_EXT     = GAP_E
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic                          in_start,
    input  logic                          in_last,
    input  logic signed [SCORE_WIDTH-1:0] S,
    input  logic signed [SCORE_WIDTH-1:0] h_left,
    input  logic signed [SCORE_WIDTH-1:0] e_left,
    input  logic signed [SCORE_WIDTH-1:0] h_up_init,
    input  logic signed [SCORE_WIDTH-1:0] h_diag_init,
    output logic                          out_valid,
    output logic                          out_start,
    output logic                          out_last,
    output logic signed [SCORE_WIDTH-1:0] h_out,
    output logic signed [SCORE_WIDTH-1:0] e_out,
    output logic signed [SCORE_WIDTH-1:0] max_score,
    output logic        [POS_WIDTH-1:0]   max_pos,
    output logic                          max_valid
);

    localparam logic signed [SCORE_WIDTH-1:0] MIN = {1'b1, {(SCORE_WIDTH-1){1'b0}}};
    localparam logic [POS_WIDTH-1:0] POS_MAX = '1;

    logic signed [SCORE_WIDTH-1:0] r_h_up, r_f_up, r_h_diag;
    logic        [POS_WIDTH-1:0]   r_row;

    logic signed [SCORE_WIDTH-1:0] w_hu, w_fu, w_hd;
    logic signed [SCORE_WIDTH-1:0] w_e_open, w_e_ext, w_e_new;
    logic signed [SCORE_WIDTH-1:0] w_f_open, w_f_ext, w_f_new;
    logic signed [SCORE_WIDTH-1:0] w_diag, w_h_max, w_h_new;

    // Recurrence terms: a start beat swaps in the column boundary instead of stored state.
    always_comb begin
        w_hu     = in_start ? h_up_init   : r_h_up;
        w_fu     = in_start ? MIN         : r_f_up;
        w_hd     = in_start ? h_diag_init : r_h_diag;
        w_e_open = SCORE_WIDTH'(sat_sub(int'(h_left), GAP_OPEN + GAP_EXT, SCORE_WIDTH));
        w_e_ext  = SCORE_WIDTH'(sat_sub(int'(e_left), GAP_EXT, SCORE_WIDTH));
        w_e_new  = (w_e_open > w_e_ext) ? w_e_open : w_e_ext;
        w_f_open = SCORE_WIDTH'(sat_sub(int'(w_hu), GAP_OPEN + GAP_EXT, SCORE_WIDTH));
        w_f_ext  = SCORE_WIDTH'(sat_sub(int'(w_fu), GAP_EXT, SCORE_WIDTH));
        w_f_new  = (w_f_open > w_f_ext) ? w_f_open : w_f_ext;
        w_diag   = SCORE_WIDTH'(sat_add(int'(w_hd), int'(S), SCORE_WIDTH));
    end

    ksw_sat_max3 #(.W(SCORE_WIDTH)) u_hmax (
        .i_a (w_diag),
        .i_b (w_e_new),
        .i_c (w_f_new),
        .o_y (w_h_max)
    );

`ifdef KSW_LOCAL_CLAMP_EN
    assign w_h_new = w_h_max[SCORE_WIDTH-1] ? '0 : w_h_max;
`else
    assign w_h_new = w_h_max;
`endif

    // Pipeline register, recurrence state, row counter and column max; bubbles hold everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_start <= 1'b0;
            out_last  <= 1'b0;
            max_valid <= 1'b0;
            h_out     <= '0;
            e_out     <= '0;
            max_score <= MIN;
            max_pos   <= '0;
            r_h_up    <= MIN;
            r_f_up    <= MIN;
            r_h_diag  <= MIN;
            r_row     <= '0;
        end else begin
            out_valid <= in_valid;
            out_start <= in_valid & in_start;
            out_last  <= in_valid & in_last;
            max_valid <= in_valid & in_last;
            if (in_valid) begin
                h_out    <= w_h_new;
                e_out    <= w_e_new;
                r_h_up   <= w_h_new;
                r_f_up   <= w_f_new;
                r_h_diag <= h_left;
                r_row    <= in_start ? POS_WIDTH'(1) : (r_row == POS_MAX) ? r_row : r_row + 1'b1;
                if (in_start || (w_h_new > max_score)) begin
                    max_score <= w_h_new;
                    max_pos   <= in_start ? '0 : r_row;
                end
            end
        end
    end

endmodule

// File: tb/tb_ksw_pe_cell.sv
// tb_ksw_pe_cell: directed-vector bench for ksw_pe_cell (q=4, e=2); honours KSW_LOCAL_CLAMP_EN
module tb_ksw_pe_cell;

    localparam logic signed [15:0] MIN = -16'sd32768;
`ifdef KSW_LOCAL_CLAMP_EN
    localparam logic signed [15:0] EXP_R1    = 16'sd0;
    localparam logic signed [15:0] EXP_NOST  = 16'sd0;
    localparam logic signed [15:0] EXP_SAT   = 16'sd0;
    localparam logic signed [15:0] EXP_RESTR = 16'sd0;
`else
    localparam logic signed [15:0] EXP_R1    = -16'sd4;
    localparam logic signed [15:0] EXP_NOST  = -16'sd6;
    localparam logic signed [15:0] EXP_SAT   = MIN;
    localparam logic signed [15:0] EXP_RESTR = -16'sd6;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic in_valid = 1'b0, in_start = 1'b0, in_last = 1'b0;
    logic signed [15:0] S = '0, h_left = '0, e_left = '0, h_up_init = '0, h_diag_init = '0;
    logic out_valid, out_start, out_last, max_valid;
    logic signed [15:0] h_out, e_out, max_score;
    logic [11:0] max_pos;
    int passed = 0;
    int total = 0;

    always #5 clk = ~clk;

    ksw_pe_cell dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_start(in_start), .in_last(in_last),
        .S(S), .h_left(h_left), .e_left(e_left), .h_up_init(h_up_init), .h_diag_init(h_diag_init),
        .out_valid(out_valid), .out_start(out_start), .out_last(out_last),
        .h_out(h_out), .e_out(e_out), .max_score(max_score), .max_pos(max_pos), .max_valid(max_valid)
    );

    task automatic beat(input logic st, input logic la, input int s, input int hl, input int el, input int hu, input int hd);
        in_valid = 1'b1; in_start = st; in_last = la;
        S = 16'(s); h_left = 16'(hl); e_left = 16'(el); h_up_init = 16'(hu); h_diag_init = 16'(hd);
        @(posedge clk); #1;
        in_valid = 1'b0; in_start = 1'b0; in_last = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b1; in_start = 1'b1; in_last = 1'b1; S = 16'sd100; h_left = 16'sd50;
        repeat (2) @(posedge clk);
        #1; rst = 1'b0; in_valid = 1'b0; in_start = 1'b0; in_last = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (out_valid !== 1'b0) $display("FAIL reset out_valid got %0b want 0", out_valid); else passed++;
        total++; if (out_start !== 1'b0 || out_last !== 1'b0) $display("FAIL reset out_start/last got %0b%0b want 00", out_start, out_last); else passed++;
        total++; if (h_out !== 16'sd0 || e_out !== 16'sd0) $display("FAIL reset h/e got %0d/%0d want 0/0", h_out, e_out); else passed++;
        total++; if (max_score !== MIN) $display("FAIL reset max_score got %0d want -32768", max_score); else passed++;
        total++; if (max_pos !== 12'd0 || max_valid !== 1'b0) $display("FAIL reset max_pos/valid got %0d/%0b want 0/0", max_pos, max_valid); else passed++;
    endtask

    task automatic test_no_start();
        do_reset();
        beat(1'b0, 1'b0, 2, 0, -32768, 0, 0);
        total++; if (h_out !== EXP_NOST) $display("FAIL nostart h_out got %0d want %0d", h_out, EXP_NOST); else passed++;
        total++; if (e_out !== -16'sd6) $display("FAIL nostart e_out got %0d want -6", e_out); else passed++;
        total++; if (max_score !== EXP_NOST || max_pos !== 12'd0) $display("FAIL nostart max got %0d@%0d want %0d@0", max_score, max_pos, EXP_NOST); else passed++;
    endtask

    task automatic test_single_row();
        beat(1'b1, 1'b1, 2, -6, -32768, 0, 0);
        total++; if (out_valid !== 1'b1 || out_start !== 1'b1 || out_last !== 1'b1) $display("FAIL single flags got %0b%0b%0b want 111", out_valid, out_start, out_last); else passed++;
        total++; if (h_out !== 16'sd2) $display("FAIL single h_out got %0d want 2", h_out); else passed++;
        total++; if (e_out !== -16'sd12) $display("FAIL single e_out got %0d want -12", e_out); else passed++;
        total++; if (max_valid !== 1'b1 || max_score !== 16'sd2 || max_pos !== 12'd0) $display("FAIL single max got v%0b %0d@%0d want v1 2@0", max_valid, max_score, max_pos); else passed++;
        @(posedge clk); #1;
        total++; if (max_valid !== 1'b0 || max_score !== 16'sd2) $display("FAIL single after max_valid/score got %0b/%0d want 0/2", max_valid, max_score); else passed++;
    endtask

    task automatic two_rows(input int gap, input string tag);
        beat(1'b1, 1'b0, 2, -6, -32768, 0, 0);
        total++; if (h_out !== 16'sd2 || e_out !== -16'sd12) $display("FAIL %s row0 h/e got %0d/%0d want 2/-12", tag, h_out, e_out); else passed++;
        total++; if (max_valid !== 1'b0 || out_last !== 1'b0) $display("FAIL %s row0 max_valid/out_last got %0b/%0b want 0/0", tag, max_valid, out_last); else passed++;
        for (int k = 0; k < gap; k++) begin
            S = 16'sd77; h_left = 16'sd99; e_left = 16'sd99;
            @(posedge clk); #1;
            total++; if (out_valid !== 1'b0 || out_start !== 1'b0) $display("FAIL %s idle out_valid/start got %0b/%0b want 0/0", tag, out_valid, out_start); else passed++;
            total++; if (h_out !== 16'sd2 || e_out !== -16'sd12 || max_score !== 16'sd2) $display("FAIL %s idle hold h/e/max got %0d/%0d/%0d want 2/-12/2", tag, h_out, e_out, max_score); else passed++;
        end
        beat(1'b0, 1'b1, -8, -8, -12, 0, 0);
        total++; if (out_valid !== 1'b1 || out_start !== 1'b0 || out_last !== 1'b1) $display("FAIL %s row1 flags got %0b%0b%0b want 101", tag, out_valid, out_start, out_last); else passed++;
        total++; if (h_out !== EXP_R1) $display("FAIL %s row1 h_out got %0d want %0d", tag, h_out, EXP_R1); else passed++;
        total++; if (e_out !== -16'sd14) $display("FAIL %s row1 e_out got %0d want -14", tag, e_out); else passed++;
        total++; if (max_valid !== 1'b1 || max_score !== 16'sd2 || max_pos !== 12'd0) $display("FAIL %s row1 max got v%0b %0d@%0d want v1 2@0", tag, max_valid, max_score, max_pos); else passed++;
    endtask

    task automatic test_two_rows();
        two_rows(0, "b2b");
    endtask

    task automatic test_bubbles();
        two_rows(3, "bubble");
    endtask

    task automatic test_max_tracking();
        beat(1'b1, 1'b0, 2, -6, -32768, 0, 0);
        beat(1'b0, 1'b0, -8, -8, -12, 0, 0);
        beat(1'b0, 1'b0, 2, 10, -32768, 0, 0);
        total++; if (h_out !== 16'sd4 || e_out !== 16'sd4) $display("FAIL track row2 h/e got %0d/%0d want 4/4", h_out, e_out); else passed++;
        total++; if (max_score !== 16'sd4 || max_pos !== 12'd2) $display("FAIL track row2 max got %0d@%0d want 4@2", max_score, max_pos); else passed++;
        beat(1'b0, 1'b1, -8, 10, -32768, 0, 0);
        total++; if (h_out !== 16'sd4) $display("FAIL track row3 h_out got %0d want 4", h_out); else passed++;
        total++; if (max_valid !== 1'b1 || max_score !== 16'sd4 || max_pos !== 12'd2) $display("FAIL track tie max got v%0b %0d@%0d want v1 4@2", max_valid, max_score, max_pos); else passed++;
        beat(1'b1, 1'b1, -8, -6, -32768, 0, 0);
        total++; if (h_out !== EXP_RESTR) $display("FAIL restart h_out got %0d want %0d", h_out, EXP_RESTR); else passed++;
        total++; if (max_score !== EXP_RESTR || max_pos !== 12'd0 || max_valid !== 1'b1) $display("FAIL restart max got v%0b %0d@%0d want v1 %0d@0", max_valid, max_score, max_pos, EXP_RESTR); else passed++;
    endtask

    task automatic test_saturation();
        beat(1'b1, 1'b1, -8, -32768, -32768, -32768, -32768);
        total++; if (h_out !== EXP_SAT) $display("FAIL sat h_out got %0d want %0d", h_out, EXP_SAT); else passed++;
        total++; if (e_out !== MIN) $display("FAIL sat e_out got %0d want -32768", e_out); else passed++;
        beat(1'b1, 1'b1, 32767, 32767, 32767, 32767, 32767);
        total++; if (h_out !== 16'sd32767) $display("FAIL sat pos h_out got %0d want 32767", h_out); else passed++;
        total++; if (e_out !== 16'sd32765) $display("FAIL sat pos e_out got %0d want 32765", e_out); else passed++;
    endtask

    initial begin
        test_reset();
        test_no_start();
        test_single_row();
        test_two_rows();
        test_bubbles();
        test_max_tracking();
        test_saturation();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
